// File: rtl/instr_mem_ctrl.sv
// Instruction memory for the fetch path: valid/ready fetch port with a 1-cycle registered
// response, a direct write port, and a bulk-load engine that streams words into sequential addresses.
module instr_mem_ctrl #(
  parameter int                 INSTR_W  = 30,
  parameter int                 DEPTH    = 64,
  parameter int                 ADDR_W   = 6,
  parameter logic [INSTR_W-1:0] INIT_VAL = INSTR_W'(1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fetch_valid,
  input  logic [ADDR_W-1:0]   fetch_addr,
  output logic                fetch_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [INSTR_W-1:0]  rsp_data,
  output logic                rsp_err,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [INSTR_W-1:0]  wr_data,
  input  logic                load_start,
  input  logic [ADDR_W-1:0]   load_base,
  input  logic [ADDR_W:0]     load_count,
  input  logic                load_valid,
  input  logic [INSTR_W-1:0]  load_data,
  output logic                load_busy,
  output logic                load_done
);

  typedef enum logic {RUN, LOAD} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W:0]     remaining;

  // Power-up image only; reset deliberately leaves the array untouched.
  logic [INSTR_W-1:0]  mem [DEPTH] = '{default: INIT_VAL};

  logic                fetch_in_range;
  logic                wr_in_range;
  logic                fetch_fire;
  logic                bypass;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [INSTR_W-1:0]  mem_wdata;
  logic [INSTR_W-1:0]  read_word;
  logic [ADDR_W-1:0]   ptr_next;

  assign fetch_in_range = 32'(fetch_addr) < DEPTH;
  assign wr_in_range    = 32'(wr_addr) < DEPTH;
  assign fetch_ready    = (state == RUN) && !load_start && (!rsp_valid || rsp_ready);
  assign fetch_fire     = fetch_valid && fetch_ready;
  assign bypass         = (state == RUN) && wr_en && wr_in_range && (wr_addr == fetch_addr);
  assign read_word      = mem[fetch_addr];
  assign ptr_next       = (32'(ptr) == DEPTH - 1) ? '0 : ptr + ADDR_W'(1);

  // The load engine owns the write port while in LOAD; direct writes are dropped then.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (state == LOAD) begin
      mem_we    = load_valid;
      mem_waddr = ptr;
      mem_wdata = load_data;
    end else begin
      mem_we    = wr_en && wr_in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Response register: new data on accept, otherwise held until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else if (fetch_fire) begin
      rsp_valid <= 1'b1;
      rsp_err   <= !fetch_in_range;
      if (!fetch_in_range) begin
        rsp_data <= INIT_VAL;
      end else if (bypass) begin
        rsp_data <= wr_data;
      end else begin
        rsp_data <= read_word;
      end
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      load_busy <= 1'b0;
      load_done <= 1'b0;
      ptr       <= '0;
      remaining <= '0;
    end else begin
      load_done <= 1'b0;
      case (state)
        RUN: begin
          if (load_start) begin
            if (load_count == '0) begin
              load_done <= 1'b1;
            end else begin
              state     <= LOAD;
              load_busy <= 1'b1;
              ptr       <= ADDR_W'(32'(load_base) % DEPTH);
              remaining <= load_count;
            end
          end
        end
        LOAD: begin
          if (load_valid) begin
            ptr       <= ptr_next;
            remaining <= remaining - (ADDR_W + 1)'(1);
            if (remaining == (ADDR_W + 1)'(1)) begin
              state     <= RUN;
              load_busy <= 1'b0;
              load_done <= 1'b1;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Bench for instr_mem_ctrl: scoreboarded fetch responses on a 64-word instance plus
// directed out-of-range checks on a 48-word instance.
module tb_instr_mem_ctrl;

  localparam int W = 30;

  typedef struct packed {
    logic [W-1:0] data;
    logic         err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_valid, fetch_ready, rsp_valid, rsp_ready, rsp_err;
  logic [5:0]    fetch_addr, wr_addr, load_base;
  logic [6:0]    load_count;
  logic [W-1:0]  rsp_data, wr_data, load_data;
  logic          wr_en, load_start, load_valid, load_busy, load_done;

  logic          f48_valid, f48_ready, r48_valid, r48_ready, r48_err, w48_en;
  logic [5:0]    f48_addr, w48_addr;
  logic [W-1:0]  r48_data, w48_data;
  logic          l48_busy, l48_done;

  logic [W-1:0]  model_mem [64];
  exp_t          sb [$];
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  instr_mem_ctrl #(.INSTR_W(W), .DEPTH(64), .ADDR_W(6), .INIT_VAL(30'h1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .load_start(load_start), .load_base(load_base), .load_count(load_count),
    .load_valid(load_valid), .load_data(load_data),
    .load_busy(load_busy), .load_done(load_done)
  );

  instr_mem_ctrl #(.INSTR_W(W), .DEPTH(48), .ADDR_W(6), .INIT_VAL(30'h1)) u_dut48 (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(f48_valid), .fetch_addr(f48_addr), .fetch_ready(f48_ready),
    .rsp_valid(r48_valid), .rsp_ready(r48_ready), .rsp_data(r48_data), .rsp_err(r48_err),
    .wr_en(w48_en), .wr_addr(w48_addr), .wr_data(w48_data),
    .load_start(1'b0), .load_base(6'd0), .load_count(7'd0),
    .load_valid(1'b0), .load_data('0),
    .load_busy(l48_busy), .load_done(l48_done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_one(input logic [5:0] a);
    fetch_valid = 1'b1;
    fetch_addr  = a;
    cyc();
    fetch_valid = 1'b0;
  endtask

  task automatic write_one(input logic [5:0] a, input logic [W-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    model_mem[a] = d;
    cyc();
    wr_en = 1'b0;
  endtask

  // Scoreboard: pop on consume, then push the expectation for a newly accepted fetch.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("rsp data=%0h err=%0b exp_data=%0h exp_err=%0b", rsp_data, rsp_err, e.data, e.err);
          chk("rsp_data", 64'(rsp_data), 64'(e.data));
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
        end
      end
      if (fetch_valid && fetch_ready) begin
        exp_t n;
        n.data = model_mem[fetch_addr];
        n.err  = 1'b0;
        sb.push_back(n);
      end
    end
  end

  initial begin
    logic       lv [5];
    logic [W-1:0] ld [5];
    lv = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    ld = '{30'd10, 30'd11, 30'd0, 30'd12, 30'd13};
    for (int i = 0; i < 64; i++) model_mem[i] = 30'h1;

    rst_n = 1'b0;
    fetch_valid = 0; fetch_addr = 0; rsp_ready = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    load_start = 0; load_base = 0; load_count = 0; load_valid = 0; load_data = 0;
    f48_valid = 0; f48_addr = 0; r48_ready = 0; w48_en = 0; w48_addr = 0; w48_data = 0;
    repeat (2) cyc();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_busy", 64'(load_busy), 64'd0);
    chk("rst_done", 64'(load_done), 64'd0);
    rst_n = 1'b1;
    cyc();

    // Back-to-back fetches of power-up contents
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch_valid = 1'b1;
      fetch_addr  = 6'(i);
      #2 chk("b2b_fready", 64'(fetch_ready), 64'd1);
      cyc();
      chk("b2b_rsp_valid", 64'(rsp_valid), 64'd1);
    end
    fetch_valid = 1'b0;
    repeat (2) cyc();

    // Direct write then fetch, and same-cycle write/fetch bypass
    write_one(6'd5, 30'h2AAAAAAA);
    fetch_one(6'd5);
    wr_en = 1'b1; wr_addr = 6'd7; wr_data = 30'h0123456;
    model_mem[7] = 30'h0123456;
    fetch_one(6'd7);
    wr_en = 1'b0;
    repeat (2) cyc();

    // Backpressure: response held, no new fetch accepted until consumed
    write_one(6'd9, 30'h155);
    write_one(6'd10, 30'h2BC);
    rsp_ready = 1'b0;
    fetch_one(6'd9);
    fetch_valid = 1'b1;
    fetch_addr  = 6'd10;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("bp_fready", 64'(fetch_ready), 64'd0);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_hold", 64'(rsp_data), 64'h155);
      cyc();
    end
    rsp_ready = 1'b1;
    #2 chk("bp_release_fready", 64'(fetch_ready), 64'd1);
    cyc();
    fetch_valid = 1'b0;
    repeat (2) cyc();

    // Bulk load wrapping past the top, with a stall and an ignored direct write
    load_start = 1'b1; load_base = 6'd62; load_count = 7'd4;
    fetch_valid = 1'b1; fetch_addr = 6'd0;
    #2 chk("ld_start_fready", 64'(fetch_ready), 64'd0);
    cyc();
    load_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      load_valid = lv[k];
      load_data  = ld[k];
      wr_en   = (k == 2);
      wr_addr = 6'd3;
      wr_data = 30'h3FF;
      #2;
      chk("ld_busy", 64'(load_busy), 64'd1);
      chk("ld_fready", 64'(fetch_ready), 64'd0);
      chk("ld_done_early", 64'(load_done), 64'd0);
      cyc();
    end
    load_valid = 1'b0; wr_en = 1'b0; fetch_valid = 1'b0;
    model_mem[62] = 30'd10; model_mem[63] = 30'd11;
    model_mem[0]  = 30'd12; model_mem[1]  = 30'd13;
    #2;
    chk("ld_done_pulse", 64'(load_done), 64'd1);
    chk("ld_busy_end", 64'(load_busy), 64'd0);
    chk("ld_fready_end", 64'(fetch_ready), 64'd1);
    cyc();
    chk("ld_done_clear", 64'(load_done), 64'd0);
    fetch_one(6'd0);
    fetch_one(6'd62);
    fetch_one(6'd63);
    fetch_one(6'd1);
    fetch_one(6'd3);
    repeat (2) cyc();

    // Reset in the middle of a load
    write_one(6'd22, 30'h777);
    load_start = 1'b1; load_base = 6'd20; load_count = 7'd4;
    cyc();
    load_start = 1'b0;
    load_valid = 1'b1; load_data = 30'h100;
    cyc();
    load_data = 30'h101;
    cyc();
    load_valid = 1'b0;
    model_mem[20] = 30'h100; model_mem[21] = 30'h101;
    rst_n = 1'b0;
    #2;
    chk("rstld_busy", 64'(load_busy), 64'd0);
    chk("rstld_done", 64'(load_done), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rstld_done_after", 64'(load_done), 64'd0);
    chk("rstld_fready", 64'(fetch_ready), 64'd1);
    for (int i = 20; i < 24; i++) fetch_one(6'(i));
    repeat (2) cyc();

    // Zero-length load
    load_start = 1'b1; load_base = 6'd30; load_count = 7'd0;
    #2 chk("zl_start_fready", 64'(fetch_ready), 64'd0);
    cyc();
    load_start = 1'b0;
    #2;
    chk("zl_done", 64'(load_done), 64'd1);
    chk("zl_busy", 64'(load_busy), 64'd0);
    chk("zl_fready", 64'(fetch_ready), 64'd1);
    cyc();
    chk("zl_done_clear", 64'(load_done), 64'd0);
    fetch_one(6'd30);
    repeat (2) cyc();

    // Out-of-range behaviour on the 48-word instance
    r48_ready = 1'b1;
    f48_valid = 1'b1; f48_addr = 6'd50;
    cyc();
    f48_valid = 1'b0;
    chk("oor_valid", 64'(r48_valid), 64'd1);
    chk("oor_data", 64'(r48_data), 64'h1);
    chk("oor_err", 64'(r48_err), 64'd1);
    w48_en = 1'b1; w48_addr = 6'd50; w48_data = 30'h3AB;
    cyc();
    w48_en = 1'b0;
    f48_valid = 1'b1; f48_addr = 6'd50;
    cyc();
    f48_valid = 1'b0;
    chk("oor_wr_data", 64'(r48_data), 64'h1);
    chk("oor_wr_err", 64'(r48_err), 64'd1);
    w48_en = 1'b1; w48_addr = 6'd47; w48_data = 30'h3AB;
    cyc();
    w48_en = 1'b0;
    f48_valid = 1'b1; f48_addr = 6'd47;
    cyc();
    f48_valid = 1'b0;
    chk("edge_data", 64'(r48_data), 64'h3AB);
    chk("edge_err", 64'(r48_err), 64'd0);
    cyc();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
- Parametrised instruction memory for the DungV fetch path. Replaces the single bidirectional instruction bus with three interfaces: a fetch request/response interface with valid/ready handshakes, a direct write port, and a sequential bulk-load engine for program download.
- Sits between the program counter/fetch stage and the decode stage.
- Adds backpressure, write-to-fetch bypass, out-of-range detection and a load state machine.

Parameters:
- INSTR_W, 30, instruction word width in bits
- DEPTH, 64, number of words; 2 <= DEPTH <= 2^ADDR_W
- ADDR_W, 6, address width in bits
- INIT_VAL, 1, power-up contents of every word; also returned for out-of-range fetches

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_valid  in  1  fetch request present
- fetch_addr  in  ADDR_W  fetch word address
- fetch_ready  out  1  request accepted this cycle when high together with fetch_valid
- rsp_valid  out  1  response register holds data
- rsp_ready  in  1  consumer takes the response
- rsp_data  out  INSTR_W  fetched instruction
- rsp_err  out  1  fetched address was >= DEPTH
- wr_en  in  1  direct single-word write
- wr_addr  in  ADDR_W  direct write address
- wr_data  in  INSTR_W  direct write data
- load_start  in  1  start a bulk load (single-cycle pulse)
- load_base  in  ADDR_W  first address of the bulk load
- load_count  in  ADDR_W+1  number of words to load, 0..DEPTH
- load_valid  in  1  load word present
- load_data  in  INSTR_W  load word
- load_busy  out  1  FSM is in LOAD
- load_done  out  1  one-cycle pulse when a load completes

Behaviour:
- Reset (async assert, sync deassert):
  - rsp_valid=0, rsp_data=0, rsp_err=0, load_busy=0, load_done=0; FSM enters RUN.
  - Memory array is not cleared. At power-up every word holds INIT_VAL; after reset, contents are retained.
- fetch_ready = (state==RUN) && !load_start && (!rsp_valid || rsp_ready). It is combinational, with no dependency on fetch_valid.
- Fetch acceptance and latency:
  - A fetch is accepted on fetch_valid && fetch_ready.
  - rsp_valid rises on the next edge, carrying mem[fetch_addr]. Latency is 1 cycle.
  - Throughput is one word per cycle while rsp_ready=1.
- Response hold: while rsp_valid && !rsp_ready, rsp_data and rsp_err are held stable. rsp_valid clears on the consume edge unless a new fetch is accepted in the same cycle.
- Out-of-range fetch: fetch_addr >= DEPTH returns rsp_data=INIT_VAL with rsp_err=1. In-range fetches give rsp_err=0.
- Direct write:
  - In RUN, wr_en writes wr_data to mem[wr_addr] at the edge.
  - wr_addr >= DEPTH is ignored.
  - wr_en is ignored in LOAD.
- Bypass: if a write and an accepted fetch target the same in-range address in the same cycle, rsp_data = wr_data (new data).
- FSM, RUN -> LOAD:
  - Triggered by load_start in RUN. Latches ptr=load_base and remaining=load_count.
  - load_start while already in LOAD is ignored.
  - If load_count=0, the FSM stays in RUN, no writes occur, and load_done pulses on the next cycle.
- FSM, LOAD:
  - load_busy=1 and fetch_ready=0.
  - Each load_valid cycle writes load_data to mem[ptr] and decrements remaining.
  - ptr increments and wraps from DEPTH-1 to 0. A load_base >= DEPTH is reduced modulo DEPTH when latched.
  - load_valid=0 stalls the load with no timeout.
- FSM, LOAD -> RUN: on the edge that writes the final word. load_done=1 for exactly the following cycle; load_busy=0 in that same cycle.
- Pending response across a load: a response already in the register when load_start arrives stays valid and is held until consumed. The load does not modify it.
- Reset mid-load: aborts the load immediately and returns the FSM to RUN. Words already written are kept. load_done does not pulse.

Test Plan:
- After reset, fetch addr 0..3 back-to-back with rsp_ready=1 -> rsp_valid from cycle 1, rsp_data=30'h1 each cycle, rsp_err=0, fetch_ready held at 1.
- Write 30'h2AAAAAAA to addr 5, then fetch 5. Separately, write 30'h0123456 to addr 7 while fetching 7 in the same cycle -> responses are 30'h2AAAAAAA and 30'h0123456 (bypass).
- Fetch addr 9 with rsp_ready=0 for 3 cycles -> fetch_ready=0, rsp_data stable, no new fetch accepted. Raise rsp_ready -> next fetch is accepted in that same cycle.
- DEPTH=48: fetch addr 50 -> rsp_data=INIT_VAL, rsp_err=1. Write to addr 50, then fetch addr 50 -> still INIT_VAL, rsp_err=1.
- Load with load_base=62, load_count=4, data 10,11,12,13, and a one-cycle load_valid gap -> mem[62]=10, mem[63]=11, mem[0]=12, mem[1]=13. load_busy=1 throughout, fetch_ready=0, load_done pulses once. A subsequent fetch of 0 returns 12.
- Assert rst_n low after 2 of 4 load words -> load_busy=0, no load_done, FSM in RUN. The first 2 words are retained and the remaining addresses still hold prior contents. Separately, load_count=0 -> load_done pulses on the next cycle with no writes.
